// File: rtl/spi_axis_txn_ctrl_if.sv
// Handshake bundle for spi_axis_txn_ctrl: command, user write/read streams and both SPI AXIS ports.
// "slave" is the controller's view; "master" is the host + SPI-interface side that surrounds it.
interface spi_axis_txn_ctrl_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_wr_len;
  logic [LEN_W-1:0] cmd_rd_len;

  logic [7:0]       s_wr_tdata;
  logic             s_wr_tvalid;
  logic             s_wr_tready;

  logic [7:0]       m_rd_tdata;
  logic             m_rd_tvalid;
  logic             m_rd_tready;
  logic             m_rd_tlast;

  logic [7:0]       spi_tx_tdata;
  logic             spi_tx_tvalid;
  logic             spi_tx_tready;

  logic [7:0]       spi_rx_tdata;
  logic             spi_rx_tvalid;
  logic             spi_rx_tready;

  modport master (
    output cmd_valid, cmd_wr_len, cmd_rd_len,
    output s_wr_tdata, s_wr_tvalid, m_rd_tready,
    output spi_tx_tready, spi_rx_tdata, spi_rx_tvalid,
    input  cmd_ready, s_wr_tready,
    input  m_rd_tdata, m_rd_tvalid, m_rd_tlast,
    input  spi_tx_tdata, spi_tx_tvalid, spi_rx_tready
  );

  modport slave (
    input  cmd_valid, cmd_wr_len, cmd_rd_len,
    input  s_wr_tdata, s_wr_tvalid, m_rd_tready,
    input  spi_tx_tready, spi_rx_tdata, spi_rx_tvalid,
    output cmd_ready, s_wr_tready,
    output m_rd_tdata, m_rd_tvalid, m_rd_tlast,
    output spi_tx_tdata, spi_tx_tvalid, spi_rx_tready
  );
endinterface

// File: rtl/spi_axis_txn_ctrl.sv
// Transaction sequencer for the byte-stream SPI master: write payload, 0x00 dummy bytes, read forwarding.
// Optional receive timeout is enabled by defining SPI_TXN_CTRL_TIMEOUT_EN.
module spi_axis_txn_ctrl #(
  parameter int LEN_W          = 8,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               resn,
  spi_axis_txn_ctrl_if.slave bus,
  output logic               busy,
  output logic               done,
  output logic               err_timeout
);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W:0]   CNT_ONE  = (LEN_W + 1)'(1);

  typedef enum logic [2:0] {IDLE, WRITE, DUMMY, DRAIN, GAP} state_t;

  state_t           state_reg;
  logic [LEN_W-1:0] wr_len_reg, rd_len_reg, tx_cnt_reg;
  logic [LEN_W:0]   total_reg, rx_cnt_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic             busy_reg, done_reg;
  logic             active, rx_keep, tx_fire, rx_fire;

  if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("spi_axis_txn_ctrl: GAP_CYCLES must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

`ifdef SPI_TXN_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  logic [TO_W-1:0] to_cnt_reg;
  logic            err_reg;
  assign err_timeout = err_reg;
`else
  assign err_timeout = 1'b0;
`endif

  assign active = (state_reg == WRITE) || (state_reg == DUMMY) || (state_reg == DRAIN);
  // Write-phase echo bytes are swallowed; anything past the expected total is treated as stray.
  assign rx_keep = active && (rx_cnt_reg >= {1'b0, wr_len_reg}) && (rx_cnt_reg < total_reg);

  assign bus.cmd_ready     = (state_reg == IDLE);
  assign bus.spi_rx_tready = rx_keep ? bus.m_rd_tready : 1'b1;
  assign bus.m_rd_tvalid   = rx_keep && bus.spi_rx_tvalid;
  assign bus.m_rd_tdata    = bus.spi_rx_tdata;
  assign bus.m_rd_tlast    = rx_keep && (rx_cnt_reg == total_reg - CNT_ONE);
  assign rx_fire           = active && bus.spi_rx_tvalid && bus.spi_rx_tready;

  always_comb begin
    bus.spi_tx_tdata  = 8'h00;
    bus.spi_tx_tvalid = 1'b0;
    bus.s_wr_tready   = 1'b0;
    case (state_reg)
      WRITE: begin
        bus.spi_tx_tdata  = bus.s_wr_tdata;
        bus.spi_tx_tvalid = bus.s_wr_tvalid;
        bus.s_wr_tready   = bus.spi_tx_tready;
      end
      DUMMY:   bus.spi_tx_tvalid = 1'b1;
      default: ;
    endcase
  end
  assign tx_fire = bus.spi_tx_tvalid && bus.spi_tx_tready;

  assign busy = busy_reg;
  assign done = done_reg;

  always_ff @(posedge clk) begin
    if (!resn) begin
      state_reg   <= IDLE;
      wr_len_reg  <= '0;
      rd_len_reg  <= '0;
      tx_cnt_reg  <= '0;
      total_reg   <= '0;
      rx_cnt_reg  <= '0;
      gap_cnt_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
`ifdef SPI_TXN_CTRL_TIMEOUT_EN
      to_cnt_reg  <= '0;
      err_reg     <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (rx_fire && rx_cnt_reg != total_reg)
        rx_cnt_reg <= rx_cnt_reg + CNT_ONE;

      case (state_reg)
        IDLE: if (bus.cmd_valid) begin
          wr_len_reg <= bus.cmd_wr_len;
          rd_len_reg <= bus.cmd_rd_len;
          total_reg  <= {1'b0, bus.cmd_wr_len} + {1'b0, bus.cmd_rd_len};
          tx_cnt_reg <= '0;
          rx_cnt_reg <= '0;
          busy_reg   <= 1'b1;
`ifdef SPI_TXN_CTRL_TIMEOUT_EN
          to_cnt_reg <= '0;
          err_reg    <= 1'b0;
`endif
          if (bus.cmd_wr_len != '0) begin
            state_reg <= WRITE;
          end else if (bus.cmd_rd_len != '0) begin
            state_reg <= DUMMY;
          end else begin
            state_reg   <= GAP;
            done_reg    <= 1'b1;
            gap_cnt_reg <= GAP_LOAD;
          end
        end
        WRITE: if (tx_fire) begin
          if (tx_cnt_reg == wr_len_reg - LEN_ONE) begin
            tx_cnt_reg <= '0;
            state_reg  <= (rd_len_reg != '0) ? DUMMY : DRAIN;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + LEN_ONE;
          end
        end
        DUMMY: if (tx_fire) begin
          if (tx_cnt_reg == rd_len_reg - LEN_ONE)
            state_reg <= DRAIN;
          else
            tx_cnt_reg <= tx_cnt_reg + LEN_ONE;
        end
        DRAIN: begin
          if (rx_cnt_reg == total_reg || (rx_fire && rx_cnt_reg == total_reg - CNT_ONE)) begin
            state_reg   <= GAP;
            done_reg    <= 1'b1;
            gap_cnt_reg <= GAP_LOAD;
          end
        end
        GAP: begin
          // TX valid is low here, letting the SPI interface release chip-select.
          if (gap_cnt_reg == '0) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase

`ifdef SPI_TXN_CTRL_TIMEOUT_EN
      // Timeout overrides any normal transition taken in the same cycle.
      if (active) begin
        if (rx_fire) begin
          to_cnt_reg <= '0;
        end else if (to_cnt_reg == TO_LAST) begin
          to_cnt_reg  <= '0;
          err_reg     <= 1'b1;
          done_reg    <= 1'b1;
          state_reg   <= GAP;
          gap_cnt_reg <= GAP_LOAD;
        end else begin
          to_cnt_reg <= to_cnt_reg + TO_ONE;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_spi_axis_txn_ctrl.sv
// Scoreboard bench for spi_axis_txn_ctrl with a simple one-byte-in-flight SPI interface model.
// Timeout scenario runs only when SPI_TXN_CTRL_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_spi_axis_txn_ctrl;
  localparam int LEN_W = 8;
  localparam int GAP   = 4;
`ifdef SPI_TXN_CTRL_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 1024;
`endif

  logic clk = 1'b0;
  logic resn = 1'b0;
  logic busy, done, err_timeout;

  spi_axis_txn_ctrl_if #(.LEN_W(LEN_W)) bus ();

  spi_axis_txn_ctrl #(
    .LEN_W(LEN_W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .resn(resn), .bus(bus),
    .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0] exp_tx_q[$];
  logic [8:0] exp_rd_q[$];   // {tlast, data}
  logic [7:0] wr_q[$];
  logic [7:0] miso_q[$];

  int done_cnt = 0, done_cyc = 0, last_cyc = 0, tx_beats = 0, rd_valid_cnt = 0;
  bit tx_fire, rx_fire, wr_fire, rd_fire, rst_seen;
  bit bp_en = 1'b0, rx_mute = 1'b0, inflight = 1'b0;
  int rx_delay = 0;
  logic [7:0] exp_b;
  logic [8:0] exp_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    cyc++;
    tx_fire  = bus.spi_tx_tvalid && bus.spi_tx_tready;
    rx_fire  = bus.spi_rx_tvalid && bus.spi_rx_tready;
    wr_fire  = bus.s_wr_tvalid && bus.s_wr_tready;
    rd_fire  = bus.m_rd_tvalid && bus.m_rd_tready;
    rst_seen = !resn;
    if (resn) begin
      if (tx_fire) begin
        tx_beats++;
        if (exp_tx_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL spi_tx_extra: got %02h, required no beat", bus.spi_tx_tdata);
        end else begin
          exp_b = exp_tx_q.pop_front();
          check("spi_tx_data", {24'd0, bus.spi_tx_tdata}, {24'd0, exp_b});
        end
      end
      if (bus.m_rd_tvalid) rd_valid_cnt++;
      if (rd_fire) begin
        if (exp_rd_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL m_rd_extra: got %02h, required no beat", bus.m_rd_tdata);
        end else begin
          exp_r = exp_rd_q.pop_front();
          check("m_rd_last_data", {23'd0, bus.m_rd_tlast, bus.m_rd_tdata}, {23'd0, exp_r});
        end
        if (bus.m_rd_tlast) last_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // SPI interface model + write-payload source + read back-pressure.
  always @(posedge clk) begin
    #1;
    if (rst_seen) begin
      inflight = 1'b0;
      rx_delay = 0;
      bus.spi_rx_tvalid = 1'b0;
      bus.spi_rx_tdata  = 8'h00;
      bus.spi_tx_tready = 1'b1;
    end else begin
      if (rx_fire) begin
        bus.spi_rx_tvalid = 1'b0;
        inflight = 1'b0;
      end
      if (tx_fire && !rx_mute) begin
        inflight = 1'b1;
        rx_delay = 1;
        bus.spi_rx_tdata = (miso_q.size() != 0) ? miso_q.pop_front() : 8'hEE;
      end else if (inflight && !bus.spi_rx_tvalid) begin
        if (rx_delay == 0) bus.spi_rx_tvalid = 1'b1;
        else rx_delay--;
      end
      bus.spi_tx_tready = rx_mute || !inflight;
    end
    if (wr_fire && wr_q.size() != 0) void'(wr_q.pop_front());
    bus.s_wr_tvalid = (wr_q.size() != 0);
    bus.s_wr_tdata  = (wr_q.size() != 0) ? wr_q[0] : 8'h00;
    bus.m_rd_tready = bp_en ? !bus.m_rd_tready : 1'b1;
  end

  task automatic send_cmd(input logic [7:0] wl, input logic [7:0] rl);
    int n = 0;
    @(posedge clk); #1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_wr_len = wl;
    bus.cmd_rd_len = rl;
    do begin @(negedge clk); n++; end while (!bus.cmd_ready && n < 200);
    check("cmd_accept", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 500);
    check(name, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.cmd_ready && n < 500);
    check("return_idle", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  task automatic check_drained(input string name);
    check({name, "_tx_left"}, exp_tx_q.size(), 0);
    check({name, "_rd_left"}, exp_rd_q.size(), 0);
  endtask

  initial begin
    int n, d0, r0;
    #500000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, r0, b0;
    bus.cmd_valid = 1'b0; bus.cmd_wr_len = '0; bus.cmd_rd_len = '0;
    resn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resn = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_err", {31'd0, err_timeout}, 0);
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 1);
    check("rst_tx_valid", {31'd0, bus.spi_tx_tvalid}, 0);
    check("rst_rd_valid", {31'd0, bus.m_rd_tvalid}, 0);
    check("rst_wr_ready", {31'd0, bus.s_wr_tready}, 0);

    // Write only: 3 bytes out, echoes dropped
    d0 = done_cnt; r0 = rd_valid_cnt;
    wr_q = '{8'hA1, 8'hA2, 8'hA3};
    exp_tx_q = '{8'hA1, 8'hA2, 8'hA3};
    miso_q = '{8'h55, 8'h66, 8'h77};
    send_cmd(8'd3, 8'd0);
    check("wo_busy", {31'd0, busy}, 1);
    wait_done("wo_done");
    wait_idle();
    check("wo_done_count", done_cnt - d0, 1);
    check("wo_rd_valid_seen", rd_valid_cnt - r0, 0);
    check_drained("wo");

    // Write then read: 9F, then three dummies; first rx byte discarded
    wr_q = '{8'h9F};
    exp_tx_q = '{8'h9F, 8'h00, 8'h00, 8'h00};
    miso_q = '{8'hA5, 8'h11, 8'h22, 8'h33};
    exp_rd_q = '{9'h011, 9'h022, 9'h133};
    send_cmd(8'd1, 8'd3);
    wait_done("wr_done");
    wait_idle();
    check("wr_done_after_last", done_cyc - last_cyc, 1);
    check_drained("wr");

    // Read-only with m_rd_tready toggling
    bp_en = 1'b1;
    exp_tx_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    miso_q = '{8'h44, 8'h55, 8'h66, 8'h77};
    exp_rd_q = '{9'h044, 9'h055, 9'h066, 9'h177};
    send_cmd(8'd0, 8'd4);
    wait_done("bp_done");
    wait_idle();
    bp_en = 1'b0;
    check("bp_done_after_last", done_cyc - last_cyc, 1);
    check_drained("bp");

    // Zero-length command, gap length, back-to-back second command
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_wr_len = 8'd0; bus.cmd_rd_len = 8'd0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.cmd_ready && n < 50);
    check("zl_accept", {31'd0, bus.cmd_ready}, 1);
    @(negedge clk);
    check("zl_done", {31'd0, done}, 1);
    check("zl_busy", {31'd0, busy}, 1);
    n = 0;
    while (!bus.cmd_ready && n < 50) begin n++; @(negedge clk); end
    check("zl_gap_len", n, GAP);
    @(negedge clk);
    check("b2b_done", {31'd0, done}, 1);
    check("b2b_cmd_ready", {31'd0, bus.cmd_ready}, 0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    wait_idle();

    // Reset in the middle of the dummy phase
    b0 = tx_beats;
    wr_q = '{8'hC1, 8'hC2};
    exp_tx_q = '{8'hC1, 8'hC2, 8'h00};
    miso_q = '{8'h01, 8'h02, 8'h03};
    send_cmd(8'd2, 8'd8);
    n = 0;
    while (tx_beats - b0 < 3 && n < 200) begin @(negedge clk); n++; end
    check("rst_mid_tx_beats", tx_beats - b0, 3);
    @(posedge clk); #1 resn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstm_busy", {31'd0, busy}, 0);
    check("rstm_cmd_ready", {31'd0, bus.cmd_ready}, 1);
    check("rstm_tx_valid", {31'd0, bus.spi_tx_tvalid}, 0);
    check("rstm_rd_valid", {31'd0, bus.m_rd_tvalid}, 0);
    check("rstm_wr_ready", {31'd0, bus.s_wr_tready}, 0);
    check_drained("rstm");
    @(posedge clk); #1 resn = 1'b1;
    miso_q.delete();
    wr_q = '{8'hD1};
    exp_tx_q = '{8'hD1, 8'h00};
    miso_q = '{8'h12, 8'h34};
    exp_rd_q = '{9'h134};
    send_cmd(8'd1, 8'd1);
    wait_done("post_rst_done");
    wait_idle();
    check_drained("post_rst");

`ifdef SPI_TXN_CTRL_TIMEOUT_EN
    // Receive never answers: timeout fires after TO_CYC idle cycles
    rx_mute = 1'b1;
    wr_q = '{8'hE1};
    exp_tx_q = '{8'hE1, 8'h00};
    send_cmd(8'd1, 8'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 200);
    check("to_done_cycle", n, TO_CYC + 1);
    check("to_err_set", {31'd0, err_timeout}, 1);
    wait_idle();
    check("to_err_sticky", {31'd0, err_timeout}, 1);
    rx_mute = 1'b0;
    send_cmd(8'd0, 8'd0);
    @(negedge clk);
    check("to_err_cleared", {31'd0, err_timeout}, 0);
    check("to_next_done", {31'd0, done}, 1);
    wait_idle();
    check_drained("to");
`else
    check("err_tied_low", {31'd0, err_timeout}, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
